// File: rtl/q_action_select_pkg.sv
// -----------------------------------------------------------------------------
// q_pkg
// Shared types and constants for the Q-learning action selector:
//   N_CELLS / Q_W / STATE_W / ADDR_W  - board and Q-table geometry
//   q_val_t                           - signed Q-value
//   cell_t                            - board cell index 0..8
//   sel_state_t                       - selector FSM states
//   mod9_nibble()                     - 4-bit value reduced modulo 9
//   first_legal_from()                - first legal cell scanning circularly
// -----------------------------------------------------------------------------
package q_pkg;

  localparam int N_CELLS = 9;
  localparam int Q_W     = 16;
  localparam int STATE_W = 15;
  localparam int ADDR_W  = 18;

  typedef logic signed [Q_W-1:0] q_val_t;
  typedef logic [3:0]            cell_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } sel_state_t;

  // A 4-bit value is at most 15, so a single conditional subtract is enough.
  function automatic cell_t mod9_nibble(input logic [3:0] v);
    return (v >= 4'd9) ? cell_t'(v - 4'd9) : cell_t'(v);
  endfunction

  // First cell with mask bit set, starting at r and wrapping 8 -> 0.
  // Returns r when the mask is empty (that case never reaches a result).
  function automatic cell_t first_legal_from(input logic [N_CELLS-1:0] mask,
                                             input cell_t              r);
    cell_t res;
    cell_t c;
    logic  found;
    res   = r;
    found = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      c = cell_t'((int'(r) + i) % N_CELLS);
      if (!found && mask[c]) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/q_action_select_if.sv
// -----------------------------------------------------------------------------
// q_action_select_if
// Q-table RAM read port.
//   q_rd_en    read strobe
//   q_rd_addr  read address (state_idx*9 + cell)
//   q_rd_data  read data, valid exactly one cycle after q_rd_en
// Modports: master = the selector, slave = the Q-table RAM.
// -----------------------------------------------------------------------------
interface q_action_select_if;
  import q_pkg::*;

  logic              q_rd_en;
  logic [ADDR_W-1:0] q_rd_addr;
  q_val_t            q_rd_data;

  modport master (output q_rd_en, output q_rd_addr, input  q_rd_data);
  modport slave  (input  q_rd_en, input  q_rd_addr, output q_rd_data);

endinterface

// File: rtl/q_action_select_max_cmp.sv
// -----------------------------------------------------------------------------
// q_max_cmp
// Combinational running-max step shared by every cell of a scan.
//   best_i / best_idx_i    current best value and its cell
//   cand_i / cand_idx_i    candidate value and its cell
//   cand_legal_i           candidate may be considered
//   first_i                no legal candidate seen yet; candidate seeds the best
//   best_o / best_idx_o    updated best value and cell
// Replacement needs a strictly greater signed value, so ties keep the earlier
// (lower-index) cell.
// -----------------------------------------------------------------------------
module q_max_cmp
  import q_pkg::*;
(
  input  q_val_t best_i,
  input  cell_t  best_idx_i,
  input  q_val_t cand_i,
  input  cell_t  cand_idx_i,
  input  logic   cand_legal_i,
  input  logic   first_i,
  output q_val_t best_o,
  output cell_t  best_idx_o
);

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    if (cand_legal_i && (first_i || (cand_i > best_i))) begin
      best_o     = cand_i;
      best_idx_o = cand_idx_i;
    end
  end

endmodule

// File: rtl/q_action_select.sv
// -----------------------------------------------------------------------------
// q_action_select
// Sequential argmax over the 9 Q-values of one board state. Reads one Q-value
// per cycle from the Q-table RAM and folds it through a single comparator.
// Fixed latency: start accepted at edge T0 -> done sampled at T11 (T1 when the
// legal mask is empty).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         request pulse, accepted only in IDLE
//   state_idx_i     board state to evaluate (sampled with start)
//   legal_mask_i    bit i set -> cell i legal (sampled with start)
//   explore_en_i    epsilon-greedy enable (sampled with start)
//   q_if            Q-table read port (master side)
//   busy_o          scan in progress (READ/DRAIN)
//   done_o          one-cycle completion pulse
//   action_o        selected cell, held until the next result
//   best_q_o        Q-value of the selected cell
//   no_move_o       legal mask was empty
//
// Configuration
//   Q_EXPLORE_EN    when defined, adds a 16-bit LFSR and epsilon-greedy
//                   exploration; otherwise explore_en_i is ignored.
// -----------------------------------------------------------------------------
module q_action_select
  import q_pkg::*;
#(
  parameter logic [7:0] EPS_THRESH = 8'd26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [STATE_W-1:0]  state_idx_i,
  input  logic [N_CELLS-1:0]  legal_mask_i,
  input  logic                explore_en_i,
  q_action_select_if.master   q_if,
  output logic                busy_o,
  output logic                done_o,
  output cell_t               action_o,
  output q_val_t              best_q_o,
  output logic                no_move_o
);

  localparam cell_t LAST_CELL = cell_t'(N_CELLS - 1);

  sel_state_t         state_q, state_d;
  cell_t              cell_q, cell_d;
  logic [STATE_W-1:0] sidx_q;
  logic [N_CELLS-1:0] mask_q;

  // Read pipeline: data on q_rd_data belongs to the cell read one cycle ago.
  logic               rd_vld_q;
  cell_t              rd_cell_q;

  // Running best across the scan.
  q_val_t             acc_val_q;
  cell_t              acc_idx_q;
  logic               acc_first_q;

  // Held result.
  cell_t              action_q;
  q_val_t             best_q_q;
  logic               no_move_q;

  logic               accept;
  logic               cand_legal;
  q_val_t             cmp_val;
  cell_t              cmp_idx;
  logic [ADDR_W-1:0]  base_addr;

  assign accept = (state_q == IDLE) && start_i;

  // state_idx*9 as shift-and-add; fits in ADDR_W for every legal state.
  assign base_addr = (ADDR_W'(sidx_q) << 3) + ADDR_W'(sidx_q);

`ifdef Q_EXPLORE_EN
  logic [15:0] lfsr_q;
  logic        explore_q;
  cell_t       expl_cell_q;
  logic        lfsr_fb;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= 16'hACE1;
      explore_q   <= 1'b0;
      expl_cell_q <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      if (accept) begin
        explore_q   <= explore_en_i && (lfsr_q[7:0] < EPS_THRESH);
        expl_cell_q <= first_legal_from(legal_mask_i, mod9_nibble(lfsr_q[11:8]));
      end
    end
  end

  // When exploring, only the pre-chosen cell is a candidate, so the comparator
  // simply captures its value and the scan latency stays unchanged.
  assign cand_legal = explore_q ? (rd_cell_q == expl_cell_q) : mask_q[rd_cell_q];
`else
  logic unused_explore;
  assign unused_explore = ^{explore_en_i, EPS_THRESH};
  assign cand_legal     = mask_q[rd_cell_q];
`endif

  q_max_cmp u_cmp (
    .best_i       (acc_val_q),
    .best_idx_i   (acc_idx_q),
    .cand_i       (q_if.q_rd_data),
    .cand_idx_i   (rd_cell_q),
    .cand_legal_i (cand_legal),
    .first_i      (acc_first_q),
    .best_o       (cmp_val),
    .best_idx_o   (cmp_idx)
  );

  // Next state and outputs.
  always_comb begin
    state_d        = state_q;
    cell_d         = cell_q;
    q_if.q_rd_en   = 1'b0;
    q_if.q_rd_addr = '0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (legal_mask_i == '0) ? DONE : READ;
          cell_d  = '0;
        end
      end
      READ: begin
        busy_o         = 1'b1;
        q_if.q_rd_en   = 1'b1;
        q_if.q_rd_addr = base_addr + ADDR_W'(cell_q);
        if (cell_q == LAST_CELL) state_d = DRAIN;
        else                     cell_d  = cell_q + cell_t'(1);
      end
      DRAIN: begin
        busy_o  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the registers are
  // few and small, so all of them are reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cell_q      <= '0;
      sidx_q      <= '0;
      mask_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_cell_q   <= '0;
      acc_val_q   <= '0;
      acc_idx_q   <= '0;
      acc_first_q <= 1'b1;
      action_q    <= '0;
      best_q_q    <= '0;
      no_move_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      rd_vld_q  <= q_if.q_rd_en;
      rd_cell_q <= cell_q;

      if (accept) begin
        sidx_q      <= state_idx_i;
        mask_q      <= legal_mask_i;
        acc_first_q <= 1'b1;
        if (legal_mask_i == '0) begin
          action_q  <= '0;
          best_q_q  <= '0;
          no_move_q <= 1'b1;
        end
      end

      if (rd_vld_q) begin
        acc_val_q <= cmp_val;
        acc_idx_q <= cmp_idx;
        if (cand_legal) acc_first_q <= 1'b0;
      end

      // DRAIN consumes cell 8; publish the comparator output directly so the
      // result is in place when done rises.
      if (state_q == DRAIN) begin
        action_q  <= cmp_idx;
        best_q_q  <= cmp_val;
        no_move_q <= 1'b0;
      end
    end
  end

  assign action_o  = action_q;
  assign best_q_o  = best_q_q;
  assign no_move_o = no_move_q;

endmodule
